// File: rtl/biu_arbiter_if.sv
// Requester/BIU signal bundle for biu_arbiter.
// master: arbiter side. slave: requesters plus BIU side.
interface biu_arbiter_if;
  logic [3:0] req;
  logic       ready1;
  logic       cs;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  logic       err;

  modport master (
    input  req, ready1,
    output cs, sel, gnt, done, busy, err
  );

  modport slave (
    output req, ready1,
    input  cs, sel, gnt, done, busy, err
  );
endinterface

// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing the BIU between mov, load/store, execution and fetch.
// Optional wait-state abort on timeout: define ARB_TIMEOUT_EN.
module biu_arbiter #(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic           clk,
  input logic           rst_n,
  biu_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t     r_state;
  logic       r_cs;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic [3:0] r_done;
  logic       r_busy;
  logic       r_err;
  logic [1:0] r_rr;

  logic       w_found;
  logic [1:0] w_idx;
  logic [1:0] w_cand;
  logic       w_timeout;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_check
    $error("biu_arbiter: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  // First set request at or above the pointer, wrapping through index 3.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = r_rr + 2'(i);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_WAIT_BUSY: r_cnt <= !bus.ready1 ? '0 : ((r_cnt == '1) ? r_cnt : r_cnt + 1'b1);
        S_WAIT_DONE: r_cnt <=  bus.ready1 ? '0 : ((r_cnt == '1) ? r_cnt : r_cnt + 1'b1);
        default:     r_cnt <= '0;
      endcase
    end
  end

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b0;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rr    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_ISSUE;
            r_gnt   <= 4'b0001 << w_idx;
            r_sel   <= w_idx;
            r_cs    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT_BUSY;
          r_cs    <= 1'b0;
        end
        S_WAIT_BUSY: begin
          if (!bus.ready1) begin
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (bus.ready1) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
            r_err   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= '0;
          r_err   <= 1'b0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_rr    <= r_sel + 2'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cs   = r_cs;
  assign bus.sel  = r_sel;
  assign bus.gnt  = r_gnt;
  assign bus.done = r_done;
  assign bus.busy = r_busy;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_biu_arbiter.sv
// Directed bench for biu_arbiter: reset, single op, round-robin order,
// late and withdrawn requests, stuck-BIU behaviour (with and without ARB_TIMEOUT_EN).
module tb_biu_arbiter;

  logic clk;
  logic rst_n;
  int unsigned n_cmp;
  int unsigned n_mis;

  biu_arbiter_if bus_if ();

  biu_arbiter #(
    .NREQ          (4),
    .TIMEOUT_CYCLES(8),
    .CNT_W         (7)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE; the BIU holds ready1 low for lo cycles after cs.
  task automatic do_txn(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input int unsigned lo, input int unsigned mid_at,
                        input logic [3:0] mid_req, input bit drop);
    int unsigned ncs;
    int unsigned bad_gnt;
    int unsigned early_done;
    ncs        = 0;
    bad_gnt    = 0;
    early_done = 0;
    tick();
    check({tag, "/cs_issue"}, 32'(bus_if.cs), 32'd1);
    check({tag, "/gnt"}, 32'(bus_if.gnt), 32'(g));
    check({tag, "/sel"}, 32'(bus_if.sel), 32'(s));
    check({tag, "/busy"}, 32'(bus_if.busy), 32'd1);
    bus_if.ready1 = 1'b0;
    for (int unsigned k = 2; k <= 2 + lo; k++) begin
      tick();
      if (bus_if.cs) ncs++;
      if (bus_if.gnt !== g || bus_if.sel !== s) bad_gnt++;
      if (k < 2 + lo && bus_if.done !== 4'b0000) early_done++;
      if (k == mid_at) bus_if.req = mid_req;
      if (k == 1 + lo) bus_if.ready1 = 1'b1;
    end
    check({tag, "/done"}, 32'(bus_if.done), 32'(g));
    check({tag, "/err"}, 32'(bus_if.err), 32'd0);
    check({tag, "/cs_extra"}, ncs, 32'd0);
    check({tag, "/gnt_stable"}, bad_gnt, 32'd0);
    check({tag, "/early_done"}, early_done, 32'd0);
    if (drop) bus_if.req = bus_if.req & ~g;
    tick();
    check({tag, "/idle_busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, "/idle_gnt"}, 32'(bus_if.gnt), 32'd0);
    check({tag, "/idle_done"}, 32'(bus_if.done), 32'd0);
  endtask

  initial begin
    logic [3:0] order_g [5];
    int unsigned bad;
    n_cmp = 0;
    n_mis = 0;
    order_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst_n         = 1'b0;
    bus_if.req    = 4'b0000;
    bus_if.ready1 = 1'b1;
    tick();
    tick();
    check("rst/cs", 32'(bus_if.cs), 32'd0);
    check("rst/sel", 32'(bus_if.sel), 32'd0);
    check("rst/gnt", 32'(bus_if.gnt), 32'd0);
    check("rst/done", 32'(bus_if.done), 32'd0);
    check("rst/busy", 32'(bus_if.busy), 32'd0);
    check("rst/err", 32'(bus_if.err), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_noreq/busy", 32'(bus_if.busy), 32'd0);

    // Reset asserted while waiting for ready1 to return.
    bus_if.req = 4'b0100;
    tick();
    check("midrst/gnt", 32'(bus_if.gnt), 32'b0100);
    bus_if.ready1 = 1'b0;
    tick();
    tick();
    check("midrst/pre_busy", 32'(bus_if.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/async_gnt", 32'(bus_if.gnt), 32'd0);
    check("midrst/async_busy", 32'(bus_if.busy), 32'd0);
    check("midrst/async_sel", 32'(bus_if.sel), 32'd0);
    tick();
    check("midrst/no_done", 32'(bus_if.done), 32'd0);
    bus_if.ready1 = 1'b1;
    rst_n = 1'b1;
    do_txn("rearb", 4'b0100, 2'd2, 3, 0, 4'b0000, 1'b1);

    bus_if.req = 4'b1000;
    do_txn("fetch", 4'b1000, 2'd3, 6, 0, 4'b0000, 1'b1);

    bus_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_txn($sformatf("rr%0d", i), order_g[i], 2'(i % 4), 3, 0, 4'b0000, 1'b0);
    end
    bus_if.req = 4'b0000;
    tick();

    // Pointer sits at 1 here; withdrawing bit1 moves it to 2, so 0011 then picks bit0.
    bus_if.req = 4'b0010;
    do_txn("withdraw", 4'b0010, 2'd1, 3, 2, 4'b0000, 1'b0);
    bus_if.req = 4'b0011;
    do_txn("rr_after_wd", 4'b0001, 2'd0, 2, 0, 4'b0000, 1'b1);
    bus_if.req = 4'b0000;

    bus_if.req = 4'b0001;
    do_txn("late_first", 4'b0001, 2'd0, 4, 3, 4'b0011, 1'b1);
    check("late/req_left", 32'(bus_if.req), 32'b0010);
    do_txn("late_second", 4'b0010, 2'd1, 2, 0, 4'b0000, 1'b1);

    // BIU never leaves idle after cs.
    bus_if.req = 4'b1000;
    tick();
    check("stuck/cs", 32'(bus_if.cs), 32'd1);
    check("stuck/gnt", 32'(bus_if.gnt), 32'b1000);
`ifdef ARB_TIMEOUT_EN
    bad = 0;
    for (int unsigned k = 2; k <= 10; k++) begin
      tick();
      if (k < 10 && bus_if.done !== 4'b0000) bad++;
    end
    check("timeout/early", bad, 32'd0);
    check("timeout/done", 32'(bus_if.done), 32'b1000);
    check("timeout/err", 32'(bus_if.err), 32'd1);
    bus_if.req = 4'b0000;
    tick();
    check("timeout/idle", 32'(bus_if.busy), 32'd0);
    check("timeout/err_clr", 32'(bus_if.err), 32'd0);
`else
    bad = 0;
    for (int unsigned k = 0; k < 100; k++) begin
      tick();
      if (!bus_if.busy || bus_if.done !== 4'b0000 || bus_if.err) bad++;
    end
    check("stuck/hold_busy", bad, 32'd0);
    bus_if.req = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("stuck/rst_busy", 32'(bus_if.busy), 32'd0);
    tick();
    rst_n = 1'b1;
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/biu_arbiter.md
Name: biu_arbiter

Overview:
- Shares the bus interface unit (BIU) between four requesters:
  - mov sequencer
  - load/store unit
  - execution unit
  - instruction fetch
- Grants one requester at a time, round-robin.
- Drives the BIU's cs/sel start pulse and tracks the BIU's combined ready1 to detect completion.
- Returns a one-cycle done pulse to the granted requester; sits between the control unit's requesters and the BIU.

Parameters:
- NREQ, 4, number of requesters; fixed at 4 because sel is 2 bits.
- TIMEOUT_CYCLES, 64, max cycles in either wait state before abort; used only with ARB_TIMEOUT_EN.
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines: bit0 mov, bit1 load/store, bit2 execution, bit3 fetch. Held high until done.
- ready1  input  1  BIU ready (high = idle/finished, low = transaction in progress).
- cs  output  1  BIU start strobe.
- sel  output  2  BIU operation select: 00 mov, 01 load/store, 10 execution, 11 fetch; equals granted index.
- gnt  output  4  one-hot grant, held from ISSUE through DONE.
- done  output  4  one-hot, one-cycle completion pulse to granted requester.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle pulse, coincident with done, on timeout abort (ARB_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst_n=0), effective immediately:
  - state=IDLE, cs=0, sel=00, gnt=0, done=0, busy=0, err=0, counter=0.
  - Round-robin pointer rr=0 (next search starts at bit0).
- Reset mid-transaction abandons the transaction without a done pulse; requesters re-request.
- States:
  - IDLE:
    - If req!=0, select the first set bit searching upward from rr with wrap (rr, rr+1, ... mod 4).
    - Register gnt and sel=index, then go to ISSUE. Otherwise stay.
  - ISSUE:
    - cs=1 for exactly this one cycle; counter cleared; go to WAIT_BUSY.
  - WAIT_BUSY:
    - cs=0. Wait for ready1=0 (BIU has left its idle state); then go to WAIT_DONE and clear the counter.
    - Otherwise increment the counter.
  - WAIT_DONE:
    - Wait for ready1=1; then go to DONE. Otherwise increment the counter.
  - DONE:
    - done=gnt for one cycle.
    - rr = granted index + 1, mod 4.
    - gnt cleared at exit; next state IDLE.
- Latency:
  - req rising in IDLE gives cs high on the 2nd edge.
  - done asserts 1 cycle after ready1 returns high.
  - Minimum IDLE-to-IDLE turnaround is 5 cycles plus BIU time.
- sel and gnt are stable from ISSUE through DONE. The BIU samples sel one cycle after cs, so sel must not change until DONE.
- Requester drops req after grant: the transaction still completes and done still pulses.
- Arbitration is evaluated only in IDLE.
- A request arriving during a transaction waits; there is no preemption.
- Simultaneous requests, with rr=0 and req=1111: grant order is 0,1,2,3,0.
  - A continuously requesting fetch therefore cannot starve the others.
- ready1 already low when entering WAIT_BUSY: move to WAIT_DONE on the next edge. This is legal because the BIU drops ready in its first post-cs cycle.
- Counter saturates at 2^CNT_W-1; it never wraps.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - In WAIT_BUSY or WAIT_DONE, when counter==TIMEOUT_CYCLES-1 and the exit condition is not met, go to DONE.
  - Assert err=1 together with done. rr advances normally.
- ARB_TIMEOUT_EN undefined:
  - No abort; the wait states wait indefinitely.
  - err is constant 0; counter logic is removed.

Test Plan:
- Reset mid-WAIT_DONE with gnt=0100: pull rst_n low asynchronously → outputs clear before the next edge, no done pulse; after release, req=0100 re-arbitrates.
- Single fetch, BIU model holds ready1 low for 6 cycles:
  - req=1000 → sel=11, gnt=1000, cs high exactly 1 cycle on the 2nd edge.
  - done=1000 one cycle after ready1 rises; busy low afterwards.
- Round-robin fairness:
  - req=1111 held, BIU model 3-cycle ops → grant order 0001,0010,0100,1000,0001, with sel 00,01,10,11,00.
- Late request:
  - req=0001 granted, then req=0011 during WAIT_DONE → bit1 granted only after done=0001 and a return to IDLE; cs never asserts while busy.
- Request withdrawn:
  - req=0010 dropped in WAIT_BUSY → transaction completes, done=0010 pulses, rr=2.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8):
  - ready1 stuck at 1 after cs → done and err pulse after 8 cycles in WAIT_BUSY; with macro undefined, busy stays high indefinitely.
